// File: rtl/obi_arbiter_2to1.sv
// Two-master to one-slave OBI arbiter: round-robin selection, address-phase
// locking, and an in-order ID FIFO that routes responses back to the issuer.

package obi_arbiter_2to1_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
  } obi_req_t;

endpackage

module obi_arbiter_2to1
  import obi_arbiter_2to1_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,

  input  logic              m0_req_i,
  output logic              m0_gnt_o,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic              m0_we_i,
  input  logic [BE_W-1:0]   m0_be_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  output logic              m0_rvalid_o,
  output logic [DATA_W-1:0] m0_rdata_o,

  input  logic              m1_req_i,
  output logic              m1_gnt_o,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic              m1_we_i,
  input  logic [BE_W-1:0]   m1_be_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic              m1_rvalid_o,
  output logic [DATA_W-1:0] m1_rdata_o,

  output logic              req_o,
  input  logic              gnt_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              we_o,
  output logic [BE_W-1:0]   be_o,
  output logic [DATA_W-1:0] wdata_o,
  input  logic              rvalid_i,
  input  logic [DATA_W-1:0] rdata_i
);

  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [CNT_W-1:0]           count_q;
  logic [PTR_W-1:0]           wr_ptr_q;
  logic [PTR_W-1:0]           rd_ptr_q;
  logic [MAX_OUTSTANDING-1:0] id_fifo_q;
  logic                       rr_ptr_q;
  logic                       lock_q;
  logic                       lock_id_q;

  logic     sel;
  logic     sel_req;
  logic     can_issue;
  logic     accept;
  logic     pop;
  logic     head_id;
  obi_req_t m0_payload;
  obi_req_t m1_payload;
  obi_req_t sel_payload;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Master selection: a pending ungranted request keeps its master selected
  always_comb begin
    sel = rr_ptr_q;
    if (lock_q) begin
      sel = lock_id_q;
    end else if (m0_req_i ^ m1_req_i) begin
      sel = m1_req_i;
    end
  end

  assign m0_payload = '{addr: m0_addr_i, we: m0_we_i, be: m0_be_i, wdata: m0_wdata_i};
  assign m1_payload = '{addr: m1_addr_i, we: m1_we_i, be: m1_be_i, wdata: m1_wdata_i};
  assign sel_payload = sel ? m1_payload : m0_payload;

  assign addr_o  = sel_payload.addr;
  assign we_o    = sel_payload.we;
  assign be_o    = sel_payload.be;
  assign wdata_o = sel_payload.wdata;

  assign sel_req   = sel ? m1_req_i : m0_req_i;
  assign can_issue = (count_q < CNT_W'(MAX_OUTSTANDING));
  assign req_o     = rst_ni & can_issue & sel_req;
  assign accept    = req_o & gnt_i;
  assign m0_gnt_o  = accept & ~sel;
  assign m1_gnt_o  = accept & sel;

  // Responses return in order, so the FIFO head names the issuing master
  assign head_id     = id_fifo_q[rd_ptr_q];
  assign pop         = rst_ni & rvalid_i & (count_q != '0);
  assign m0_rvalid_o = pop & ~head_id;
  assign m1_rvalid_o = pop & head_id;
  assign m0_rdata_o  = rdata_i;
  assign m1_rdata_o  = rdata_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      id_fifo_q <= '0;
      rr_ptr_q  <= 1'b0;
      lock_q    <= 1'b0;
      lock_id_q <= 1'b0;
    end else begin
      if (accept) begin
        id_fifo_q[wr_ptr_q] <= sel;
        wr_ptr_q            <= ptr_inc(wr_ptr_q);
        rr_ptr_q            <= ~sel;
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      unique case ({accept, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      // Hold the selection while the slave stalls the address phase
      lock_q <= req_o & ~gnt_i;
      if (req_o && !gnt_i) begin
        lock_id_q <= sel;
      end
    end
  end

endmodule

// File: tb/tb_obi_arbiter_2to1.sv
// Directed bench for obi_arbiter_2to1 (MAX_OUTSTANDING=2): reset, routing,
// round-robin, lock, full and spurious-response cases.

module tb_obi_arbiter_2to1;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        m0_req_i, m0_gnt_o, m0_we_i, m0_rvalid_o;
  logic [31:0] m0_addr_i, m0_wdata_i, m0_rdata_o;
  logic [3:0]  m0_be_i;
  logic        m1_req_i, m1_gnt_o, m1_we_i, m1_rvalid_o;
  logic [31:0] m1_addr_i, m1_wdata_i, m1_rdata_o;
  logic [3:0]  m1_be_i;
  logic        req_o, gnt_i, we_o, rvalid_i;
  logic [31:0] addr_o, wdata_o, rdata_i;
  logic [3:0]  be_o;

  int vec_cnt = 0;
  int err_cnt = 0;

  obi_arbiter_2to1 #(.MAX_OUTSTANDING(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m0_req_i(m0_req_i), .m0_gnt_o(m0_gnt_o), .m0_addr_i(m0_addr_i), .m0_we_i(m0_we_i),
    .m0_be_i(m0_be_i), .m0_wdata_i(m0_wdata_i), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req_i), .m1_gnt_o(m1_gnt_o), .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i),
    .m1_be_i(m1_be_i), .m1_wdata_i(m1_wdata_i), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
    .req_o(req_o), .gnt_i(gnt_i), .addr_o(addr_o), .we_o(we_o), .be_o(be_o), .wdata_o(wdata_o),
    .rvalid_i(rvalid_i), .rdata_i(rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic r0, input logic r1, input logic g, input logic rv,
                       input logic [31:0] rd);
    m0_req_i = r0;
    m1_req_i = r1;
    gnt_i    = g;
    rvalid_i = rv;
    rdata_i  = rd;
    #1;
  endtask

  initial begin
    rst_ni = 1'b0;
    m0_addr_i = 32'h100; m0_we_i = 1'b0; m0_be_i = 4'hF; m0_wdata_i = 32'h0;
    m1_addr_i = 32'h200; m1_we_i = 1'b1; m1_be_i = 4'hA; m1_wdata_i = 32'hCAFE_F00D;

    // Reset forces the slave request and all grants/responses low
    drive(1, 0, 1, 1, 32'h0);
    chk("rst_req", 32'(req_o), 0);
    chk("rst_m0_gnt", 32'(m0_gnt_o), 0);
    chk("rst_m0_rvalid", 32'(m0_rvalid_o), 0);
    tick();
    tick();

    rst_ni = 1'b1;
    drive(0, 0, 0, 0, 32'h0);
    chk("idle_sel_m0", addr_o, 32'h100);
    chk("idle_req", 32'(req_o), 0);

    // Spurious response with nothing outstanding
    drive(0, 0, 0, 1, 32'h1234);
    chk("spur_m0_rvalid", 32'(m0_rvalid_o), 0);
    chk("spur_m1_rvalid", 32'(m1_rvalid_o), 0);
    chk("spur_rdata", m0_rdata_o, 32'h1234);
    tick();

    // Single m0 read
    drive(1, 0, 1, 0, 32'h0);
    chk("rd_req", 32'(req_o), 1);
    chk("rd_m0_gnt", 32'(m0_gnt_o), 1);
    chk("rd_m1_gnt", 32'(m1_gnt_o), 0);
    chk("rd_addr", addr_o, 32'h100);
    tick();
    drive(0, 0, 0, 1, 32'hDEAD_BEEF);
    chk("rd_m0_gnt_off", 32'(m0_gnt_o), 0);
    chk("rd_m0_rvalid", 32'(m0_rvalid_o), 1);
    chk("rd_m1_rvalid", 32'(m1_rvalid_o), 0);
    chk("rd_m0_rdata", m0_rdata_o, 32'hDEAD_BEEF);
    tick();

    // Lone m1 write, then reset drops its outstanding ID
    drive(0, 1, 1, 0, 32'h0);
    chk("wr_m1_gnt", 32'(m1_gnt_o), 1);
    chk("wr_addr", addr_o, 32'h200);
    chk("wr_we", 32'(we_o), 1);
    chk("wr_be", 32'(be_o), 32'hA);
    chk("wr_wdata", wdata_o, 32'hCAFE_F00D);
    tick();
    rst_ni = 1'b0;
    drive(0, 0, 0, 1, 32'h0);
    chk("mid_rst_m1_rvalid", 32'(m1_rvalid_o), 0);
    tick();
    rst_ni = 1'b1;
    drive(0, 0, 0, 1, 32'h0);
    chk("post_rst_m1_rvalid", 32'(m1_rvalid_o), 0);
    chk("post_rst_m0_rvalid", 32'(m0_rvalid_o), 0);
    tick();

    // Round-robin with continuous requests
    m0_addr_i = 32'h10; m1_addr_i = 32'h20; m1_we_i = 1'b0;
    drive(1, 1, 1, 0, 32'h0);
    chk("rr0_addr", addr_o, 32'h10);
    chk("rr0_m0_gnt", 32'(m0_gnt_o), 1);
    tick();
    drive(1, 1, 1, 1, 32'hA0);
    chk("rr1_addr", addr_o, 32'h20);
    chk("rr1_m1_gnt", 32'(m1_gnt_o), 1);
    chk("rr1_m0_rvalid", 32'(m0_rvalid_o), 1);
    tick();
    drive(1, 1, 1, 1, 32'hA1);
    chk("rr2_addr", addr_o, 32'h10);
    chk("rr2_m0_gnt", 32'(m0_gnt_o), 1);
    chk("rr2_m1_rvalid", 32'(m1_rvalid_o), 1);
    chk("rr2_m0_rvalid", 32'(m0_rvalid_o), 0);
    tick();
    // Accept+pop at count=1 left exactly one outstanding
    drive(0, 0, 0, 1, 32'hA2);
    chk("rr3_m0_rvalid", 32'(m0_rvalid_o), 1);
    tick();
    drive(0, 0, 0, 1, 32'hA3);
    chk("rr4_m0_rvalid", 32'(m0_rvalid_o), 0);
    chk("rr4_m1_rvalid", 32'(m1_rvalid_o), 0);
    tick();

    // Lone m1 transaction returns rr priority to m0
    drive(0, 1, 1, 0, 32'h0);
    chk("m1solo_gnt", 32'(m1_gnt_o), 1);
    tick();
    drive(0, 0, 0, 1, 32'h0);
    chk("m1solo_rvalid", 32'(m1_rvalid_o), 1);
    tick();

    // Slave stalls three cycles: m0 stays selected
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 0, 32'h0);
      chk("lock_addr", addr_o, 32'h10);
      chk("lock_req", 32'(req_o), 1);
      chk("lock_m0_gnt", 32'(m0_gnt_o), 0);
      tick();
    end
    drive(1, 1, 1, 0, 32'h0);
    chk("lock_rel_addr", addr_o, 32'h10);
    chk("lock_rel_m0_gnt", 32'(m0_gnt_o), 1);
    tick();
    drive(1, 1, 1, 1, 32'h0);
    chk("lock_next_m1_gnt", 32'(m1_gnt_o), 1);
    chk("lock_next_addr", addr_o, 32'h20);
    chk("lock_next_m0_rvalid", 32'(m0_rvalid_o), 1);
    tick();
    drive(0, 0, 0, 1, 32'h0);
    chk("lock_m1_rvalid", 32'(m1_rvalid_o), 1);
    tick();

    // m1 locked first; a later m0 request must not steal the selection
    drive(0, 1, 0, 0, 32'h0);
    chk("lock1_addr", addr_o, 32'h20);
    tick();
    drive(1, 1, 0, 0, 32'h0);
    chk("lock1_hold_addr", addr_o, 32'h20);
    tick();
    drive(1, 1, 1, 0, 32'h0);
    chk("lock1_m1_gnt", 32'(m1_gnt_o), 1);
    chk("lock1_m0_gnt", 32'(m0_gnt_o), 0);
    tick();
    drive(1, 0, 1, 0, 32'h0);
    chk("fill_m0_gnt", 32'(m0_gnt_o), 1);
    tick();

    // Full: no accept even with a same-cycle response
    drive(0, 1, 1, 1, 32'h0);
    chk("full_req", 32'(req_o), 0);
    chk("full_m1_gnt", 32'(m1_gnt_o), 0);
    chk("full_m1_rvalid", 32'(m1_rvalid_o), 1);
    tick();
    drive(0, 1, 1, 0, 32'h0);
    chk("unfull_req", 32'(req_o), 1);
    chk("unfull_m1_gnt", 32'(m1_gnt_o), 1);
    tick();
    drive(0, 0, 0, 1, 32'h0);
    chk("drain0_m0_rvalid", 32'(m0_rvalid_o), 1);
    tick();
    drive(0, 0, 0, 1, 32'h0);
    chk("drain1_m1_rvalid", 32'(m1_rvalid_o), 1);
    tick();
    drive(0, 0, 0, 1, 32'h0);
    chk("drain2_m0_rvalid", 32'(m0_rvalid_o), 0);
    chk("drain2_m1_rvalid", 32'(m1_rvalid_o), 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/obi_arbiter_2to1.md
Name: obi_arbiter_2to1

Overview:
- Shares one OBI slave port between two OBI master ports (m0, m1), e.g. the wb_to_obi bridge and a core data port in front of a single SRAM/peripheral slave.
- Arbitrates round-robin, locks selection for the duration of an ungranted request, and tracks outstanding transactions in an ID FIFO.
- Returns each in-order response to the master that issued it.

Parameters:
- MAX_OUTSTANDING, 2: max accepted-but-unanswered transactions; power of 2, range 1..8.
- CNT_W, $clog2(MAX_OUTSTANDING+1): width of the outstanding counter (derived; do not override).

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_ni  in  1  synchronous, active-low reset.
- m0_req_i  in  1  master 0 address-phase request.
- m0_gnt_o  out  1  grant to master 0.
- m0_addr_i  in  32  master 0 address.
- m0_we_i  in  1  master 0 write enable.
- m0_be_i  in  4  master 0 byte enables.
- m0_wdata_i  in  32  master 0 write data.
- m0_rvalid_o  out  1  response valid to master 0.
- m0_rdata_o  out  32  response data to master 0.
- m1_*: identical set for master 1.
- req_o  out  1  request to slave.
- gnt_i  in  1  grant from slave.
- addr_o  out  32  muxed address.
- we_o  out  1  muxed write enable.
- be_o  out  4  muxed byte enables.
- wdata_o  out  32  muxed write data.
- rvalid_i  in  1  slave response valid.
- rdata_i  in  32  slave response data.

Behaviour:
- Reset (rst_ni=0 at clock edge):
  - count=0; FIFO rd/wr pointers=0; rr_ptr=0 (m0 has priority); lock=0.
  - While rst_ni=0, outputs are forced: req_o=0, m0/m1_gnt_o=0, m0/m1_rvalid_o=0.
  - Reset mid-transaction drops all outstanding IDs; later rvalid_i is ignored as the empty case.
- Selection (combinational):
  - If lock=1, sel=lock_id.
  - Else if only one master requests, sel=that master.
  - Else if both request, sel=rr_ptr.
- Address phase:
  - can_issue = (count < MAX_OUTSTANDING).
  - req_o = can_issue && m[sel]_req_i.
  - addr/we/be/wdata_o are the sel master's signals; m[sel]_gnt_o = gnt_i && req_o; the other gnt_o=0.
- Accept = req_o && gnt_i:
  - push sel into the ID FIFO.
  - rr_ptr <= ~sel.
  - lock <= 0.
- Lock:
  - If req_o=1 and gnt_i=0, then lock <= 1 and lock_id <= sel.
  - This keeps slave-facing address signals stable until gnt (OBI rule).
  - Masters must hold req until gnt; a master dropping req while locked is a protocol violation (lock clears when req_o falls).
- Full:
  - count == MAX_OUTSTANDING forces req_o=0, so no accept.
  - A same-cycle rvalid does not permit an accept; the next accept happens the cycle after count decrements.
- Response:
  - Slave responses are in order.
  - If rvalid_i && count>0, then m[head]_rvalid_o=1, pop FIFO.
  - m0_rdata_o = m1_rdata_o = rdata_i, unconditionally.
- Empty: rvalid_i with count==0 is ignored; no rvalid_o, count stays 0.
- Counter:
  - accept only: +1.
  - pop only: −1.
  - both: unchanged (FIFO pushes and pops in the same cycle).
  - Pointers wrap modulo MAX_OUTSTANDING.
- Latency: zero-cycle combinational grant and response pass-through; no added bubbles for back-to-back accepts while not full.

Test Plan:
- Reset/idle: rst_ni=0 with m0_req=1, gnt_i=1 → req_o=0, m0_gnt_o=0; after release, count=0 and m0 is selected first.
- Single master read: m0 reads addr 0x100 with gnt same cycle, then rvalid_i=1 with rdata 0xDEADBEEF one cycle later → m0_gnt_o 1 cycle, m0_rvalid_o=1 with 0xDEADBEEF, m1_rvalid_o=0.
- Round-robin: both masters request continuously with gnt_i=1 and 0x10/0x20 addresses → addr_o alternates 0x10, 0x20, 0x10; responses route m0, m1, m0.
- Lock: both request, gnt_i=0 for 3 cycles then 1 → addr_o stays at m0's address all 4 cycles; m1 is granted on the next accept.
- Full (MAX_OUTSTANDING=2): two accepts with no rvalid → req_o=0 on the third cycle despite m1_req=1; one rvalid → req_o=1 the following cycle.
- Spurious rvalid: rvalid_i=1 with count=0 → both rvalid_o=0, count remains 0; simultaneous accept+rvalid at count=1 → count stays 1.
